// File: rtl/addr_gen_upd_wr.sv
// addr_gen_upd_wr: write-address generator for the LSTM update-parameter
// weight-gradient RAM. Accepts one accumulated dW word per i_valid, in
// cell-major order, and issues registered write enable / address / data.
// A one-cycle o_done pulse marks the end of NUM_CELL*NUM_INPUT writes.
module addr_gen_upd_wr #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 24,
  parameter int NUM_CELL   = 8,
  parameter int NUM_INPUT  = 53,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  i_start,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  // Counter widths are clamped to one bit so degenerate 1x1 geometries still build.
  localparam int IN_W   = (NUM_INPUT > 1) ? $clog2(NUM_INPUT) : 1;
  localparam int CELL_W = (NUM_CELL  > 1) ? $clog2(NUM_CELL)  : 1;

  localparam logic [IN_W-1:0]       IN_LAST   = IN_W'(NUM_INPUT - 1);
  localparam logic [IN_W-1:0]       IN_ZERO   = {IN_W{1'b0}};
  localparam logic [IN_W-1:0]       IN_ONE    = IN_W'(1);
  localparam logic [CELL_W-1:0]     CELL_LAST = CELL_W'(NUM_CELL - 1);
  localparam logic [CELL_W-1:0]     CELL_ZERO = {CELL_W{1'b0}};
  localparam logic [CELL_W-1:0]     CELL_ONE  = CELL_W'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  // Encoded states; the spare code 2'd3 falls back to IDLE.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            state_q,    state_d;
  logic [IN_W-1:0]       in_cnt_q,   in_cnt_d;
  logic [CELL_W-1:0]     cell_cnt_q, cell_cnt_d;
  logic [ADDR_WIDTH-1:0] ptr_q,      ptr_d;
  logic                  we_q,       we_d;
  logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
  logic [DATA_WIDTH-1:0] data_q,     data_d;
  logic                  done_q,     done_d;
  logic                  err_q,      err_d;

  // Next-state, counter, pointer and output-register computation.
  always_comb begin
    state_d    = state_q;
    in_cnt_d   = in_cnt_q;
    cell_cnt_d = cell_cnt_q;
    ptr_d      = ptr_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    done_d     = 1'b0;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d    = S_RUN;
          in_cnt_d   = IN_ZERO;
          cell_cnt_d = CELL_ZERO;
          ptr_d      = ADDR_BASE;
        end else begin
          state_d    = S_IDLE;
        end
        // A result arriving while idle is dropped and flagged; it wins over
        // the clear from a coincident start so the stray word is never lost
        // silently.
        err_d = (i_start ? 1'b0 : err_q) | i_valid;
      end

      S_RUN: begin
        // en low is a pause: i_valid is ignored and nothing advances.
        if (en && i_valid) begin
          we_d   = 1'b1;
          addr_d = ptr_q;
          data_d = i_data;
          ptr_d  = ptr_q + ADDR_ONE;
          if (in_cnt_q != IN_LAST) begin
            in_cnt_d = in_cnt_q + IN_ONE;
          end else begin
            in_cnt_d = IN_ZERO;
            if (cell_cnt_q != CELL_LAST) begin
              cell_cnt_d = cell_cnt_q + CELL_ONE;
            end else begin
              state_d = S_DONE;
            end
          end
        end else begin
          we_d = 1'b0;
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        err_d   = err_q | i_valid;
      end

      default: begin
        state_d    = S_IDLE;
        in_cnt_d   = IN_ZERO;
        cell_cnt_d = CELL_ZERO;
        ptr_d      = ADDR_BASE;
      end
    endcase
  end

  // State, counters and registered RAM-side outputs; async active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      in_cnt_q   <= IN_ZERO;
      cell_cnt_q <= CELL_ZERO;
      ptr_q      <= ADDR_BASE;
      we_q       <= 1'b0;
      addr_q     <= ADDR_BASE;
      data_q     <= DATA_ZERO;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_cnt_q   <= in_cnt_d;
      cell_cnt_q <= cell_cnt_d;
      ptr_q      <= ptr_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign o_we   = we_q;
  assign o_addr = addr_q;
  assign o_data = data_q;
  assign o_done = done_q;
  assign o_err  = err_q;
  assign o_busy = (state_q == S_RUN);

endmodule
